// File: rtl/display_buf_loader.sv
`timescale 1ns/1ps
// Double-buffered display memory: host fills a hidden back bank, the bank swap is committed on the
// synchronised vsync assertion edge. Define DISPLAY_BUF_IMMEDIATE_EN to swap as soon as a frame is complete.
module display_buf_loader #(
  parameter int DEPTH            = 65,
  parameter int DW               = 8,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         wr_valid,
  input  logic [DW-1:0]                wr_data,
  output logic                         wr_ready,
  input  logic                         vsync,
  output logic [DW-1:0]                ram [DEPTH],
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fill_count,
  output logic                         frame_done
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic          VS_ACT   = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic          VS_INACT = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic          front_sel;
  logic [DW-1:0] bank [2][DEPTH];

  logic vs_meta, vs_sync, vs_prev;
  logic vs_edge, commit, wr_fire;

  // Two synchroniser stages followed by the edge register; all idle at the inactive sync level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta <= VS_INACT;
      vs_sync <= VS_INACT;
      vs_prev <= VS_INACT;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign vs_edge = (vs_sync == VS_ACT) && (vs_prev != VS_ACT);

`ifdef DISPLAY_BUF_IMMEDIATE_EN
  assign commit = 1'b1;
`else
  assign commit = vs_edge;
`endif

  // start always wins over a same-cycle byte, so ready is masked by it.
  assign wr_ready = (state == FILL) && !start;
  assign wr_fire  = wr_valid && wr_ready;

  // NOTE: the banks carry an async reset on purpose: a reset must blank the visible frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++)
          bank[b][i] <= '0;
    end else if (wr_fire) begin
      bank[~front_sel][ptr] <= wr_data;
    end
  end

  // NOTE: always_comb with a full assignment of every element means no latch can be inferred here.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ram[i] = bank[front_sel][i];
  end

  // NOTE: state and all registered outputs use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      fill_count <= '0;
      front_sel  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state      <= FILL;
        busy       <= 1'b1;
        ptr        <= '0;
        fill_count <= '0;
      end else begin
        case (state)
          FILL: begin
            if (wr_valid) begin
              fill_count <= fill_count + CW'(1);
              if (ptr == LAST_PTR) state <= PEND;
              else                 ptr   <= ptr + PW'(1);
            end
          end
          PEND: begin
            if (commit) begin
              front_sel  <= ~front_sel;
              frame_done <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
              fill_count <= '0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_buf_loader.sv
`timescale 1ns/1ps
// Self-checking bench for display_buf_loader: vector table, directed frame sequences and a
// randomized run against a frame-level reference model. Honours DISPLAY_BUF_IMMEDIATE_EN.
module tb_display_buf_loader;

  localparam int DEPTH = 65;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          vsync = 1'b1;
  logic          wr_ready;
  logic [DW-1:0] ram [DEPTH];
  logic          busy;
  logic [CW-1:0] fill_count;
  logic          frame_done;

  display_buf_loader #(.DEPTH(DEPTH), .DW(DW), .VSYNC_ACTIVE_LOW(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .vsync      (vsync),
    .ram        (ram),
    .busy       (busy),
    .fill_count (fill_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_ram   [DEPTH];
  logic [DW-1:0] frame_buf [DEPTH];

  // Frame-level reference model state
  bit            m_loading, m_pending;
  logic [DW-1:0] m_q [$];
  logic          vh [4];

  typedef struct {
    logic          st;
    logic          v;
    logic [DW-1:0] d;
    logic          exp_rdy;
    logic [CW-1:0] exp_fc;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_ram(input string name);
    int bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== exp_ram[i] && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: ram[%0d] got %0h expected %0h", name, bad, ram[bad], exp_ram[bad]);
    end
  endtask

  // Inputs change on the falling edge; outputs are looked at 1ns later.
  task automatic drive(input logic s, input logic v, input logic [DW-1:0] d);
    @(negedge clk);
    start    = s;
    wr_valid = v;
    wr_data  = d;
    #1;
  endtask

  task automatic load_frame(input string name);
    bit ready_ok = 1'b1;
    drive(1'b1, 1'b1, 8'h77);
    check({name, "_ready_on_start"}, wr_ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, frame_buf[i]);
      if (i == 0) check({name, "_fc_after_start"}, fill_count, 0);
      if (wr_ready !== 1'b1) ready_ok = 1'b0;
    end
    check({name, "_ready_fill"}, ready_ok, 1'b1);
    drive(1'b0, 1'b1, 8'hEE);
    check({name, "_ready_pend"}, wr_ready, 1'b0);
    check({name, "_fc_full"}, fill_count, DEPTH);
    check({name, "_busy_pend"}, busy, 1'b1);
  endtask

  task automatic commit_frame(input string name);
`ifdef DISPLAY_BUF_IMMEDIATE_EN
    check_ram({name, "_old_before_swap"});
    check({name, "_fd_before"}, frame_done, 1'b0);
    @(negedge clk); #1;
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = frame_buf[i];
    check_ram({name, "_new"});
    check({name, "_fd_pulse"}, frame_done, 1'b1);
    @(negedge clk); #1;
    check({name, "_fd_single"}, frame_done, 1'b0);
    check({name, "_busy_idle"}, busy, 1'b0);
    check({name, "_fc_idle"}, fill_count, 0);
`else
    drive(1'b0, 1'b0, 8'h00);
    vsync = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk); #1;
      check_ram({name, "_old_before_swap"});
      check({name, "_fd_early"}, frame_done, 1'b0);
    end
    @(negedge clk); #1;
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = frame_buf[i];
    check_ram({name, "_new_3clk"});
    check({name, "_fd_pulse"}, frame_done, 1'b1);
    @(negedge clk); #1;
    check({name, "_fd_single"}, frame_done, 1'b0);
    check({name, "_busy_idle"}, busy, 1'b0);
    check({name, "_fc_idle"}, fill_count, 0);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fd_seen, ok;
    logic st, vv, exp_rdy, commit_ok, m_fd;
    logic [DW-1:0] d;

    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, CW'(0), 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h77, 1'b0, CW'(0), 1'b1};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, CW'(0), 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'hA0, 1'b1, CW'(1), 1'b1};
    vecs[4] = '{1'b0, 1'b1, 8'hA1, 1'b1, CW'(2), 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, CW'(2), 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h55, 1'b0, CW'(0), 1'b1};
    vecs[7] = '{1'b0, 1'b1, 8'h66, 1'b1, CW'(1), 1'b1};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, CW'(0), 1'b1};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b1, CW'(0), 1'b1};

    // Reset and quiet period
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fd_seen = 1'b0;
    repeat (10) begin
      @(negedge clk); #1;
      if (frame_done !== 1'b0) fd_seen = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = '0;
    check_ram("reset_ram");
    check("reset_ready", wr_ready, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_fc", fill_count, 0);
    check("reset_no_fd", fd_seen, 1'b0);

    // Handshake vector table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].st, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d_ready", i), wr_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_fc", i), fill_count, vecs[i].exp_fc);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end
    check_ram("vec_front_untouched");

    // Full frame 0x00..0x40
    for (int i = 0; i < DEPTH; i++) frame_buf[i] = DW'(i);
    load_frame("ramp");
    commit_frame("ramp");

    // Abandoned partial frame, then a full 0xA5 frame
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 8'h3C);
    drive(1'b0, 1'b0, 8'h00);
    check("partial_fc", fill_count, 20);
    for (int i = 0; i < DEPTH; i++) frame_buf[i] = 8'hA5;
    load_frame("restart");
    commit_frame("restart");

    // Full frame held pending without vsync
    for (int i = 0; i < DEPTH; i++) frame_buf[i] = DW'(i) ^ 8'h5A;
    load_frame("hold");
`ifndef DISPLAY_BUF_IMMEDIATE_EN
    ok = 1'b1;
    repeat (1000) begin
      drive(1'b0, 1'b1, 8'hC3);
      if (wr_ready !== 1'b0 || fill_count !== CW'(DEPTH) || busy !== 1'b1 || frame_done !== 1'b0) ok = 1'b0;
    end
    check("hold_pending_1000", ok, 1'b1);
    check_ram("hold_old_frame");
`endif
    commit_frame("hold");

    // Async reset mid-fill
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, DW'(i + 1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = '0;
    check_ram("midfill_reset_ram");
    check("midfill_reset_busy", busy, 1'b0);
    check("midfill_reset_fc", fill_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      drive(1'b0, 1'b1, 8'h99);
      if (wr_ready !== 1'b0) ok = 1'b0;
    end
    check("post_reset_ignore_valid", ok, 1'b1);
    @(posedge clk); #1;
    check("post_reset_fc", fill_count, 0);
    check("post_reset_busy", busy, 1'b0);
    check_ram("post_reset_ram");

    // Randomized run against the frame-level model
    m_loading = 1'b0;
    m_pending = 1'b0;
    m_q.delete();
    for (int i = 0; i < 4; i++) vh[i] = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      st = (!m_loading && !m_pending) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      vv = ($urandom_range(0, 3) != 0);
      d  = DW'($urandom);
      drive(st, vv, d);
      if ($urandom_range(0, 15) == 0) vsync = ~vsync;
      exp_rdy = m_loading && !st;
      check("rand_ready", wr_ready, exp_rdy);

      // vsync history as seen at this edge: vh[n] = level applied n edges ago
      vh[3] = vh[2];
      vh[2] = vh[1];
      vh[1] = vh[0];
      vh[0] = vsync;
`ifdef DISPLAY_BUF_IMMEDIATE_EN
      commit_ok = 1'b1;
`else
      commit_ok = (vh[2] == 1'b0) && (vh[3] == 1'b1);
`endif
      m_fd = 1'b0;
      if (st) begin
        m_loading = 1'b1;
        m_pending = 1'b0;
        m_q.delete();
      end else if (m_loading && vv) begin
        m_q.push_back(d);
        if (m_q.size() == DEPTH) begin
          m_loading = 1'b0;
          m_pending = 1'b1;
        end
      end else if (m_pending && commit_ok) begin
        for (int i = 0; i < DEPTH; i++) exp_ram[i] = m_q[i];
        m_q.delete();
        m_pending = 1'b0;
        m_fd = 1'b1;
      end

      @(posedge clk); #1;
      check("rand_fd", frame_done, m_fd);
      check("rand_fc", fill_count, m_q.size());
      check("rand_busy", busy, m_loading || m_pending);
      check_ram("rand_ram");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
